// File: rtl/csla_pkg.sv
// Shared carry-select helpers: slice width, slice type and the
// binary-to-excess-one converter used to form the cin=1 alternate.
package csla_pkg;

   localparam int SLICE_W = 4;

   typedef logic [SLICE_W-1:0] slice_t;

   // {carry, x + 1} built as a toggle chain rather than a full adder
   function automatic logic [SLICE_W:0] bec4(input slice_t x);
      logic [SLICE_W:0] r;
      logic t;
      t = 1'b1;
      for (int i = 0; i < SLICE_W; i++) begin
         r[i] = x[i] ^ t;
         t    = t & x[i];
      end
      r[SLICE_W] = t;
      return r;
   endfunction

endpackage

// File: rtl/csla_slice.sv
// One carry-select slice: 4-bit CLA with cin=0, BEC for the cin=1
// alternate, and the select mux driven by the incoming carry.
module csla_slice
   import csla_pkg::*;
(
   input  slice_t a,
   input  slice_t b,
   input  logic   cin_sel,
   output slice_t s,
   output logic   cout
);

   slice_t           g;
   slice_t           p;
   slice_t           sum0;
   slice_t           sum1;
   logic             co0;
   logic             co1;
   logic [SLICE_W:0] bec;
   logic [3:1]       c;

   always_comb begin
      g    = a & b;
      p    = a ^ b;
      c[1] = g[0];
      c[2] = g[1] | (p[1] & g[0]);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
      co0  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]);
      sum0 = p ^ {c[3], c[2], c[1], 1'b0};
      bec  = bec4(sum0);
      sum1 = bec[SLICE_W-1:0];
      // cin=1 carries out if cin=0 already did or sum0 is all ones
      co1  = co0 | bec[SLICE_W];
      s    = cin_sel ? sum1 : sum0;
      cout = cin_sel ? co1 : co0;
   end

endmodule

// File: rtl/csla_sub_pipe.sv
// Two-stage carry-select subtractor (a + ~b + 1) with valid/ready
// flow control and borrow/zero/overflow flags.
module csla_sub_pipe
   import csla_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             zero,
   output logic             ovf
);

   localparam int LO_W = WIDTH / 2;
   localparam int HI_W = WIDTH - LO_W;
   localparam int N_LO = LO_W / SLICE;
   localparam int N_HI = HI_W / SLICE;

   logic [WIDTH-1:0] nb;
   logic [LO_W-1:0]  lo_sum;
   logic [HI_W-1:0]  hi_sum;
   logic [N_LO:0]    c_lo;
   logic [N_HI:0]    c_hi;
   logic [WIDTH-1:0] full;
   logic             s1_adv;
   logic             s2_adv;

   logic             s1_valid_q, s1_valid_d;
   logic [LO_W-1:0]  lo_q, lo_d;
   logic             c_lo_q, c_lo_d;
   logic [HI_W-1:0]  a_hi_q, a_hi_d;
   logic [HI_W-1:0]  nb_hi_q, nb_hi_d;
   logic             a_sgn_q, a_sgn_d;
   logic             b_sgn_q, b_sgn_d;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_q, borrow_d;
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;

   assign nb      = ~b;
   assign c_lo[0] = 1'b1;
   assign c_hi[0] = c_lo_q;

   for (genvar g = 0; g < N_LO; g++) begin : g_lo
      csla_slice u_slice (
         .a       (a[g*SLICE_W +: SLICE_W]),
         .b       (nb[g*SLICE_W +: SLICE_W]),
         .cin_sel (c_lo[g]),
         .s       (lo_sum[g*SLICE_W +: SLICE_W]),
         .cout    (c_lo[g+1])
      );
   end

   for (genvar g = 0; g < N_HI; g++) begin : g_hi
      csla_slice u_slice (
         .a       (a_hi_q[g*SLICE_W +: SLICE_W]),
         .b       (nb_hi_q[g*SLICE_W +: SLICE_W]),
         .cin_sel (c_hi[g]),
         .s       (hi_sum[g*SLICE_W +: SLICE_W]),
         .cout    (c_hi[g+1])
      );
   end

   assign full   = {hi_sum, lo_q};
   assign s2_adv = !out_valid_q || out_ready;
   assign s1_adv = !s1_valid_q || s2_adv;

   always_comb begin
      s1_valid_d  = s1_valid_q;
      lo_d        = lo_q;
      c_lo_d      = c_lo_q;
      a_hi_d      = a_hi_q;
      nb_hi_d     = nb_hi_q;
      a_sgn_d     = a_sgn_q;
      b_sgn_d     = b_sgn_q;
      out_valid_d = out_valid_q;
      diff_d      = diff_q;
      borrow_d    = borrow_q;
      zero_d      = zero_q;
      ovf_d       = ovf_q;
      if (s1_adv) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            lo_d    = lo_sum;
            c_lo_d  = c_lo[N_LO];
            a_hi_d  = a[WIDTH-1:LO_W];
            nb_hi_d = nb[WIDTH-1:LO_W];
            a_sgn_d = a[WIDTH-1];
            b_sgn_d = b[WIDTH-1];
         end
      end
      if (s2_adv) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            diff_d   = full;
            borrow_d = ~c_hi[N_HI];
            zero_d   = (full == '0);
            ovf_d    = (a_sgn_q != b_sgn_q) && (full[WIDTH-1] != a_sgn_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         lo_q        <= '0;
         c_lo_q      <= 1'b0;
         a_hi_q      <= '0;
         nb_hi_q     <= '0;
         a_sgn_q     <= 1'b0;
         b_sgn_q     <= 1'b0;
         out_valid_q <= 1'b0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         lo_q        <= lo_d;
         c_lo_q      <= c_lo_d;
         a_hi_q      <= a_hi_d;
         nb_hi_q     <= nb_hi_d;
         a_sgn_q     <= a_sgn_d;
         b_sgn_q     <= b_sgn_d;
         out_valid_q <= out_valid_d;
         diff_q      <= diff_d;
         borrow_q    <= borrow_d;
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
      end
   end

   assign in_ready  = s1_adv;
   assign out_valid = out_valid_q;
   assign diff      = diff_q;
   assign borrow    = borrow_q;
   assign zero      = zero_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_csla_sub_pipe.sv
// Scoreboard bench for csla_sub_pipe: directed vectors, stream,
// stall, mid-flight reset and a random handshake soak.
module tb_csla_sub_pipe;

   typedef struct {
      logic [15:0] d;
      logic        bo;
      logic        z;
      logic        o;
      int          cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        borrow;
   logic        zero;
   logic        ovf;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic chk_lat = 1'b0;
   logic chk_consec = 1'b0;
   logic have_prev = 1'b0;
   int   prev_cyc = 0;

   csla_sub_pipe #(.WIDTH(16), .SLICE(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .zero      (zero),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("diff", 32'(diff), 32'(e.d));
            chk("flags{borrow,zero,ovf}", 32'({borrow, zero, ovf}),
                32'({e.bo, e.z, e.o}));
            if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd2);
            if (chk_consec && have_prev)
               chk("consecutive", 32'(cyc - prev_cyc), 32'd1);
            have_prev = 1'b1;
            prev_cyc  = cyc;
         end
      end
   end

   task automatic push(input logic [15:0] ed, input logic eb, ez, eo);
      exp_t e;
      e.d = ed; e.bo = eb; e.z = ez; e.o = eo; e.cyc = cyc;
      q.push_back(e);
   endtask

   task automatic send(input logic [15:0] ta, tb_, ed, input logic eb, ez, eo);
      int n;
      n = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; a = ta; b = tb_;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (in_ready) push(ed, eb, ez, eo);
      else begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
      end
   endtask

   task automatic push_model(input logic [15:0] ta, tb_);
      logic [15:0] d;
      d = ta - tb_;
      push(d, ta < tb_, d == 16'h0, (ta[15] != tb_[15]) && (d[15] != ta[15]));
   endtask

   task automatic idle();
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((q.size() != 0 || out_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_left", 32'(q.size()), 32'd0);
   endtask

   logic [15:0] sa [4];
   logic [15:0] sb [4];
   logic [15:0] sd [4];
   logic [2:0]  sf [4];

   initial begin
      int          idx;
      logic [15:0] held;
      int          sent;
      int          guard;
      logic        pend;
      logic [15:0] ra, rb;

      sa[0] = 16'h3000; sb[0] = 16'h1000; sd[0] = 16'h2000; sf[0] = 3'b000;
      sa[1] = 16'h0005; sb[1] = 16'h0007; sd[1] = 16'hFFFE; sf[1] = 3'b100;
      sa[2] = 16'h8001; sb[2] = 16'h0002; sd[2] = 16'h7FFF; sf[2] = 3'b001;
      sa[3] = 16'h4444; sb[3] = 16'h4444; sd[3] = 16'h0000; sf[3] = 3'b010;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_flags", 32'({borrow, zero, ovf}), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      chk_lat = 1'b1;
      send(16'h1234, 16'h0234, 16'h1000, 0, 0, 0);
      send(16'h0000, 16'h0001, 16'hFFFF, 1, 0, 0);
      send(16'h8000, 16'h0001, 16'h7FFF, 0, 0, 1);
      send(16'h0100, 16'h0001, 16'h00FF, 0, 0, 0);
      send(16'h5A5A, 16'h5A5A, 16'h0000, 0, 1, 0);
      send(16'h7FFF, 16'hFFFF, 16'h8000, 1, 0, 1);
      send(16'hFFFF, 16'hFFFF, 16'h0000, 0, 1, 0);
      idle();
      wait_drain();

      chk_consec = 1'b1; have_prev = 1'b0;
      send(16'h0010, 16'h0001, 16'h000F, 0, 0, 0);
      send(16'h0001, 16'h0010, 16'hFFF1, 1, 0, 0);
      send(16'hFFFF, 16'h0001, 16'hFFFE, 0, 0, 0);
      send(16'h8000, 16'h8000, 16'h0000, 0, 1, 0);
      send(16'h00FF, 16'h00FF, 16'h0000, 0, 1, 0);
      send(16'h1000, 16'h0FFF, 16'h0001, 0, 0, 0);
      send(16'h7FFF, 16'h8000, 16'hFFFF, 1, 0, 1);
      send(16'hABCD, 16'h1234, 16'h9999, 0, 0, 0);
      idle();
      wait_drain();
      chk_consec = 1'b0;

      // stall: consumer blocked for 5 cycles while producer keeps offering
      chk_lat = 1'b0;
      idx = 0; held = '0;
      @(posedge clk); #1 out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; a = sa[idx]; b = sb[idx];
         @(negedge clk);
         if (in_ready) begin
            push(sd[idx], sf[idx][2], sf[idx][1], sf[idx][0]);
            idx++;
         end
         if (k == 2) held = diff;
      end
      chk("stall_accepts", 32'(idx), 32'd2);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_diff_stable", 32'(diff), 32'(held));
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 2; k < 4; k++)
         send(sa[k], sb[k], sd[k], sf[k][2], sf[k][1], sf[k][0]);
      idle();
      wait_drain();

      // reset with two ops in flight
      @(posedge clk); #1 out_ready = 1'b0;
      send(16'h0F00, 16'h0100, 16'h0E00, 0, 0, 0);
      send(16'h0002, 16'h0003, 16'hFFFF, 1, 0, 0);
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      q.delete();
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);
      chk("post_rst_diff", 32'(diff), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      chk_lat = 1'b1;
      send(16'h0100, 16'h0001, 16'h00FF, 0, 0, 0);
      idle();
      wait_drain();

      // random soak with random in_valid / out_ready
      chk_lat = 1'b0;
      sent = 0; guard = 0; pend = 1'b0; ra = '0; rb = '0;
      while (sent < 2000 && guard < 30000) begin
         @(posedge clk); #1;
         guard++;
         out_ready = ($urandom_range(0, 3) != 0);
         if (!pend && $urandom_range(0, 3) != 0) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            pend = 1'b1;
         end
         in_valid = pend; a = ra; b = rb;
         @(negedge clk);
         if (pend && in_ready) begin
            push_model(ra, rb);
            pend = 1'b0;
            sent++;
         end
      end
      chk("random_sent", 32'(sent), 32'd2000);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
